jump_ctl: RTL
=============

Name: jump_ctl

Overview:
- Consumes the player key levels (key_space, key_left, key_right) from the keyboard controller stage.
- Converts them into movement commands for the player physics block: walk requests, a charged-jump power value, a launch direction and a one-cycle launch strobe.
- Implements the charge-and-release jump: hold space to charge, release to jump. It sequences ground/air state from the physics block's on_ground flag.

Parameters:
- CHARGE_W, 6: width of charge counter and jump_power.
- CHARGE_MAX, 63: saturation value of charge (must be at most 2^CHARGE_W-1).
- CHARGE_STEP, 1: increment applied per tick while charging.
- MIN_POWER, 4: floor applied to jump_power at launch.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- key_space  in  1  jump key level, 1 = held.
- key_left  in  1  left key level.
- key_right  in  1  right key level.
- tick  in  1  one-cycle frame strobe; charge advances only on tick.
- on_ground  in  1  from physics; 1 = player standing on a surface.
- walk_left  out  1  walk-left request (level).
- walk_right  out  1  walk-right request (level).
- charging  out  1  1 while in CHARGE state.
- charge_level  out  CHARGE_W  live charge counter.
- jump_start  out  1  one-cycle launch strobe.
- jump_power  out  CHARGE_W  power of last launch; held until next launch.
- jump_dir  out  2  direction of last launch: 00 vertical, 01 right, 10 left; held.

Behaviour:
- Reset is synchronous, active-high, on clk. It sets:
  - state = IDLE, armed = 0;
  - charge_level = 0, jump_power = 0, jump_dir = 00;
  - all 1-bit outputs = 0.
- All outputs are registered and change 1 cycle after the inputs that cause them.
- dir_in (combinational): 01 if key_right & ~key_left; 10 if key_left & ~key_right; else 00.
- armed: cleared on reset and on every LAUNCH. Set in any cycle where key_space = 0. A held space never starts a second charge.
- IDLE:
  - walk_left = (dir_in == 10), walk_right = (dir_in == 01).
  - If on_ground = 0 → AIR; walk outputs 0 next cycle.
  - Else if key_space & armed → CHARGE; charge_level cleared to 0.
  - on_ground = 0 takes priority over a charge request.
- CHARGE:
  - walk outputs 0; charging = 1.
  - On tick: charge_level = min(charge_level + CHARGE_STEP, CHARGE_MAX). The sum is computed one bit wider, so there is no wrap.
  - dir_latch tracks dir_in every cycle.
  - If on_ground = 0 → AIR with no jump_start; charge_level cleared; abort wins over release.
  - Else if key_space = 0 → LAUNCH.
- LAUNCH (exactly 1 cycle):
  - jump_start = 1.
  - jump_power = max(charge_level, MIN_POWER).
  - jump_dir = dir_latch at the release cycle.
  - charge_level cleared; armed cleared.
  - Next state AIR_WAIT.
- AIR_WAIT:
  - Waits for physics to leave the ground: on_ground = 0 → AIR.
  - If on_ground stays 1 for 255 consecutive cycles (8-bit timeout), return to IDLE.
- AIR:
  - walk outputs 0; key inputs ignored apart from arming.
  - on_ground = 1 → IDLE.
- tick coinciding with release: the increment is discarded and launch uses the pre-tick charge.
- Reset mid-CHARGE: no jump_start is issued; all values return to reset state.

Optional Feature:
- Macro: JUMP_AUTO_RELEASE_EN.
- Defined: when charge_level reaches CHARGE_MAX in CHARGE, the next cycle enters LAUNCH even while key_space = 1. armed stays 0 until space is released.
- Undefined: charge holds at CHARGE_MAX until key_space falls.

Test Plan:
1. rst 2 cycles, then key_space = 1 with on_ground = 1 and no prior low → no CHARGE (armed = 0). Drop space for 1 cycle, then raise it → charging = 1 after 1 cycle, charge_level = 0.
2. Charge for 10 ticks, then release with key_right = 1 → single jump_start pulse, jump_power = 10, jump_dir = 01. Next, on_ground 1→0→1 → returns to IDLE.
3. Charge for 2 ticks, release with no direction → jump_power = 4 (MIN_POWER), jump_dir = 00.
4. Hold space for 100 ticks → charge_level saturates at 63 and never wraps. With JUMP_AUTO_RELEASE_EN: jump_start 1 cycle after reaching 63, and no second jump while space is still held.
5. In CHARGE at level 7, drop on_ground → AIR, jump_start stays 0, charge_level = 0; jump_power keeps its previous value.
6. IDLE with key_left & key_right both 1 → walk_left = walk_right = 0. key_left alone → walk_left = 1 after 1 cycle. Launch, then on_ground held at 1 → IDLE after 255 cycles.

Source files
------------

// File: rtl/jump_ctl.sv
// -----------------------------------------------------------------------------
// jump_ctl
//
// Turns the player's key levels into movement commands for the physics block.
// Space works as charge-and-release: hold it to charge, let go to jump. Left
// and right produce walk requests while standing idle. They also set the
// direction of a jump. The controller follows ground and air state from the
// physics block's on_ground flag.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   key_space     jump key level (1 = held)
//   key_left      left key level
//   key_right     right key level
//   tick          one-cycle frame strobe; charge advances only on tick
//   on_ground     from physics, 1 = standing on a surface
//   walk_left     walk-left request (level)
//   walk_right    walk-right request (level)
//   charging      1 while charging a jump
//   charge_level  live charge counter
//   jump_start    one-cycle launch strobe
//   jump_power    power of the last launch, held until the next launch
//   jump_dir      direction of the last launch: 00 vertical, 01 right, 10 left
//
// Every output is registered and responds one cycle after its cause.
//
// Build option:
//   JUMP_AUTO_RELEASE_EN  When defined, a charge that reaches CHARGE_MAX
//                         launches on the next cycle even if space is still
//                         held. When undefined, the charge holds at CHARGE_MAX
//                         until space is released.
// -----------------------------------------------------------------------------
module jump_ctl #(
  parameter int CHARGE_W    = 6,
  parameter int CHARGE_MAX  = 63,
  parameter int CHARGE_STEP = 1,
  parameter int MIN_POWER   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_space,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                tick,
  input  logic                on_ground,
  output logic                walk_left,
  output logic                walk_right,
  output logic                charging,
  output logic [CHARGE_W-1:0] charge_level,
  output logic                jump_start,
  output logic [CHARGE_W-1:0] jump_power,
  output logic [1:0]          jump_dir
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CHARGE   = 3'd1,
    S_LAUNCH   = 3'd2,
    S_AIR_WAIT = 3'd3,
    S_AIR      = 3'd4
  } state_e;

  localparam logic [1:0] DIR_NONE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;

  // The charge sum is formed one bit wider so that saturation is decided
  // before any wrap could occur.
  localparam logic [CHARGE_W:0]   STEP_X = (CHARGE_W + 1)'(CHARGE_STEP);
  localparam logic [CHARGE_W:0]   MAX_X  = (CHARGE_W + 1)'(CHARGE_MAX);
  localparam logic [CHARGE_W-1:0] MAX_C  = CHARGE_W'(CHARGE_MAX);
  localparam logic [CHARGE_W-1:0] MIN_C  = CHARGE_W'(MIN_POWER);

  // AIR_WAIT gives up after 255 consecutive grounded cycles. The counter
  // starts at 0, so the last grounded cycle is the one that sees 254.
  localparam logic [7:0] TIMEOUT_LAST = 8'd254;

`ifdef JUMP_AUTO_RELEASE_EN
  localparam bit AUTO_RELEASE = 1'b1;
`else
  localparam bit AUTO_RELEASE = 1'b0;
`endif

  // State and registered outputs
  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  walk_left_q, walk_left_d;
  logic                  walk_right_q, walk_right_d;
  logic                  charging_q, charging_d;
  logic                  jump_start_q, jump_start_d;
  logic [CHARGE_W-1:0]   charge_level_q, charge_level_d;
  logic [CHARGE_W-1:0]   jump_power_q, jump_power_d;
  logic [1:0]            jump_dir_q, jump_dir_d;

  // Combinational helpers
  logic [1:0]            dir_in;
  logic [CHARGE_W:0]     charge_sum;
  logic [CHARGE_W-1:0]   charge_inc;
  logic [CHARGE_W-1:0]   launch_power;

  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block. A path that leaves a signal unassigned would infer a latch.
  always_comb begin
    dir_in = DIR_NONE;
    if (key_right && !key_left) begin
      dir_in = DIR_RIGHT;
    end else if (key_left && !key_right) begin
      dir_in = DIR_LEFT;
    end

    charge_sum = {1'b0, charge_level_q} + STEP_X;
    charge_inc = (charge_sum > MAX_X) ? MAX_C : charge_sum[CHARGE_W-1:0];

    // The power comes from the pre-tick level, so a tick that coincides
    // with the release is discarded.
    launch_power = (charge_level_q < MIN_C) ? MIN_C : charge_level_q;
  end

  always_comb begin
    state_d        = state_q;
    charge_level_d = charge_level_q;
    jump_power_d   = jump_power_q;
    jump_dir_d     = jump_dir_q;
    wait_cnt_d     = wait_cnt_q;
    // Any cycle with space up re-arms. The state cases below may still
    // consume the arm.
    armed_d        = armed_q | ~key_space;

    unique case (state_q)
      S_IDLE: begin
        // A fall takes priority over a new charge.
        if (!on_ground) begin
          state_d = S_AIR;
        end else if (key_space && armed_q) begin
          state_d        = S_CHARGE;
          charge_level_d = '0;
          // Consume the arm so that a space held through an aborted charge
          // cannot start another charge after landing.
          armed_d        = 1'b0;
        end
      end

      S_CHARGE: begin
        if (!on_ground) begin
          // Abort: leaving the ground wins over a release in the same cycle.
          state_d        = S_AIR;
          charge_level_d = '0;
        end else if (!key_space || (AUTO_RELEASE && (charge_level_q == MAX_C))) begin
          state_d        = S_LAUNCH;
          jump_power_d   = launch_power;
          // The direction latch follows dir_in every cycle. Its value in the
          // release cycle becomes the launch direction.
          jump_dir_d     = dir_in;
          charge_level_d = '0;
        end else if (tick) begin
          charge_level_d = charge_inc;
        end
      end

      S_LAUNCH: begin
        // Clear the arm even if space is still held. This matters after an
        // auto-release, where only a release of space may re-arm.
        armed_d    = 1'b0;
        wait_cnt_d = '0;
        state_d    = S_AIR_WAIT;
      end

      S_AIR_WAIT: begin
        if (!on_ground) begin
          state_d = S_AIR;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_AIR: begin
        if (on_ground) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d        = S_IDLE;
        charge_level_d = '0;
      end
    endcase

    // The outputs are decoded from the next state. After the register
    // they line up cycle-for-cycle with state_q.
    walk_left_d  = (state_d == S_IDLE) && (dir_in == DIR_LEFT);
    walk_right_d = (state_d == S_IDLE) && (dir_in == DIR_RIGHT);
    charging_d   = (state_d == S_CHARGE);
    jump_start_d = (state_d == S_LAUNCH);
  end

  // NOTE: sequential state uses non-blocking assignments only, so that every
  // flop samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      armed_q        <= 1'b0;
      wait_cnt_q     <= '0;
      walk_left_q    <= 1'b0;
      walk_right_q   <= 1'b0;
      charging_q     <= 1'b0;
      jump_start_q   <= 1'b0;
      charge_level_q <= '0;
      jump_power_q   <= '0;
      jump_dir_q     <= DIR_NONE;
    end else begin
      state_q        <= state_d;
      armed_q        <= armed_d;
      wait_cnt_q     <= wait_cnt_d;
      walk_left_q    <= walk_left_d;
      walk_right_q   <= walk_right_d;
      charging_q     <= charging_d;
      jump_start_q   <= jump_start_d;
      charge_level_q <= charge_level_d;
      jump_power_q   <= jump_power_d;
      jump_dir_q     <= jump_dir_d;
    end
  end

  assign walk_left    = walk_left_q;
  assign walk_right   = walk_right_q;
  assign charging     = charging_q;
  assign charge_level = charge_level_q;
  assign jump_start   = jump_start_q;
  assign jump_power   = jump_power_q;
  assign jump_dir     = jump_dir_q;

endmodule
